// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debounce array.
// Holds the per-channel FSM state type and the counter sizing function.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        REPT = 2'd2
    } key_state_e;

    // Bits needed to hold a count of 0..cycles; a zero count still gets one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchroniser, debounce counter and a
// press/hold/repeat FSM generating single-cycle event pulses.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int DEB_CYCLES    = 50000,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic          INACTIVE  = ACTIVE_LOW;

    logic          sync1;
    logic          sync2;
    logic          act;
    logic [DW-1:0] deb_cnt;
    logic          mismatch;
    logic          deb_done;
    logic          press_evt;
    logic          release_evt;

    key_state_e    state;
    key_state_e    state_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nx;
    logic          long_nx;
    logic          repeat_nx;

    // Synchroniser resets to the idle pad level so reset never looks like a press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= i_in;
            sync2 <= sync1;
        end
    end

    assign act         = sync2 ^ ACTIVE_LOW;
    assign mismatch    = (act != o_level);
    assign deb_done    = mismatch && (deb_cnt == DEB_LAST);
    assign press_evt   = deb_done && !o_level;
    assign release_evt = deb_done && o_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            deb_cnt <= '0;
            o_level <= 1'b0;
        end else begin
            if (!mismatch || deb_done) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            if (deb_done) begin
                o_level <= !o_level;
            end
        end
    end

    // Release is checked first so a release on a terminal count suppresses long/repeat.
    always_comb begin
        state_nx  = state;
        hold_nx   = hold_cnt;
        rep_nx    = rep_cnt;
        long_nx   = 1'b0;
        repeat_nx = 1'b0;
        case (state)
            IDLE: begin
                if (press_evt) begin
                    state_nx = HELD;
                    hold_nx  = '0;
                end
            end
            HELD: begin
                if (release_evt) begin
                    state_nx = IDLE;
                    hold_nx  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    long_nx  = 1'b1;
                    state_nx = REPT;
                    hold_nx  = '0;
                    rep_nx   = '0;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            REPT: begin
                if (release_evt) begin
                    state_nx = IDLE;
                    rep_nx   = '0;
                end else if (REPEAT_CYCLES != 0) begin
                    if (rep_cnt == REP_LAST) begin
                        repeat_nx = 1'b1;
                        rep_nx    = '0;
                    end else begin
                        rep_nx = rep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
                rep_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            rep_cnt   <= rep_nx;
            o_press   <= press_evt;
            o_release <= release_evt;
            o_long    <= long_nx;
            o_repeat  <= repeat_nx;
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// N-channel key conditioner: one independent debounce/event channel per key pin.
// Sits between the board KEY pins and the core's key event inputs.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int DEB_CYCLES    = 50000,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_in,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            key_debounce_channel #(
                .ACTIVE_LOW   (ACTIVE_LOW),
                .DEB_CYCLES   (DEB_CYCLES),
                .LONG_CYCLES  (LONG_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES)
            ) u_ch (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_in     (i_in[g]),
                .o_level  (o_level[g]),
                .o_press  (o_press[g]),
                .o_release(o_release[g]),
                .o_long   (o_long[g]),
                .o_repeat (o_repeat[g])
            );
        end
    endgenerate

endmodule
